// File: rtl/audio_i2s_pkg.sv
// Shared definitions for the I2S ADC receiver: receiver states, the I2S
// one-bit delay slot and the default captured sample width.
`timescale 1ns/1ps
package audio_i2s_pkg;

    localparam int unsigned DEFAULT_SAMPLE_BITS = 16;
    // Bit clocks between an LR-clock edge and the MSB of the new channel.
    localparam int unsigned I2S_DELAY           = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer with an optional single-cycle rise pulse.
// Ports:
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   async_i    asynchronous input
//   sync_o     synchronized level (registered)
//   rise_c_o   combinational pulse: sync_o went 0 -> 1 (0 when RISE_EN=0)
`timescale 1ns/1ps
module i2s_sync #(
    parameter bit RISE_EN = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_c_o
);

    logic [1:0] sync_q;

    // Metastability chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    assign sync_o = sync_q[1];

    if (RISE_EN) begin : g_rise
        logic prev_q;

        // Previous synchronized level for edge detection.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                prev_q <= 1'b0;
            end else begin
                prev_q <= sync_q[1];
            end
        end

        assign rise_c_o = sync_q[1] & ~prev_q;
    end else begin : g_no_rise
        assign rise_c_o = 1'b0;
    end

endmodule

// File: rtl/audio_i2s_rx.sv
// I2S ADC receiver: oversamples the codec bit clock, deserializes left and
// right words MSB first and presents them as a stereo pair on a valid/ready
// interface with a sticky overflow flag for dropped pairs.
// Ports:
//   clk, reset                         system clock, async active-high reset
//   audio_bclk/adclrc/adcdat           codec serial interface (asynchronous)
//   enable                             receiver enable
//   out_valid/out_ready                pair handshake
//   out_left/out_right [W-1:0]         stereo pair
//   overflow/clr_overflow              sticky drop flag and its clear
`timescale 1ns/1ps
module audio_i2s_rx
    import audio_i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS      = DEFAULT_SAMPLE_BITS,
    parameter int unsigned MIN_CLK_PER_BCLK = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   audio_bclk,
    input  logic                   audio_adclrc,
    input  logic                   audio_adcdat,
    input  logic                   enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAMPLE_BITS-1:0] out_left,
    output logic [SAMPLE_BITS-1:0] out_right,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int unsigned W     = SAMPLE_BITS;
    localparam int unsigned CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
    localparam logic [CNT_W-1:0] MSB_POS  = CNT_W'(W - 1);

    // Reject unsupported widths; a zero clk/bclk ratio is meaningless.
    if (SAMPLE_BITS < 8 || SAMPLE_BITS > 32 || MIN_CLK_PER_BCLK == 0) begin : g_bad_cfg
        $error("audio_i2s_rx: illegal parameter set");
    end

    logic bclk_rise_c;
    logic lrc_s;
    logic dat_s;
    logic bclk_s_unused;
    logic lrc_rise_unused;
    logic dat_rise_unused;

    i2s_sync #(.RISE_EN(1'b1)) u_sync_bclk (
        .clk_i(clk), .rst_i(reset), .async_i(audio_bclk),
        .sync_o(bclk_s_unused), .rise_c_o(bclk_rise_c)
    );
    i2s_sync #(.RISE_EN(1'b0)) u_sync_lrc (
        .clk_i(clk), .rst_i(reset), .async_i(audio_adclrc),
        .sync_o(lrc_s), .rise_c_o(lrc_rise_unused)
    );
    i2s_sync #(.RISE_EN(1'b0)) u_sync_dat (
        .clk_i(clk), .rst_i(reset), .async_i(audio_adcdat),
        .sync_o(dat_s), .rise_c_o(dat_rise_unused)
    );

    rx_state_t        state_q, state_d;
    logic             prev_lrc_q, prev_lrc_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [W-1:0]     left_hold_q, left_hold_d;
    logic             left_vld_q, left_vld_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_left_q, out_left_d;
    logic [W-1:0]     out_right_q, out_right_d;
    logic             overflow_q, overflow_d;
    logic             word_done_c;
    logic [W-1:0]     word_c;
    logic             pair_form_c;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prev_lrc_q  <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_lrc_q  <= prev_lrc_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            left_vld_q  <= left_vld_d;
            out_valid_q <= out_valid_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            overflow_q  <= overflow_d;
        end
    end

    // Framing FSM, deserializer, pairing and output handshake.
    always_comb begin
        state_d     = state_q;
        prev_lrc_d  = prev_lrc_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_vld_d  = left_vld_q;
        out_valid_d = out_valid_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        overflow_d  = overflow_q;
        word_done_c = 1'b0;
        word_c      = shift_q;
        pair_form_c = 1'b0;

        if (bclk_rise_c) begin
            prev_lrc_d = lrc_s;
            if (lrc_s != prev_lrc_q) begin
                // Delay slot: close a short word left-justified, start new channel.
                if (state_q != ST_IDLE && bit_cnt_q != CNT_FULL) begin
                    word_done_c = 1'b1;
                end
                bit_cnt_d = '0;
                shift_d   = '0;
                if (!lrc_s) begin
                    state_d = ST_LEFT;
                end else if (state_q == ST_LEFT) begin
                    state_d = ST_RIGHT;
                end else begin
                    state_d = ST_IDLE;
                end
            end else if (state_q != ST_IDLE && bit_cnt_q != CNT_FULL) begin
                // Place the bit at its MSB-first position; LSBs stay zero.
                shift_d   = shift_q | (W'(dat_s) << (MSB_POS - bit_cnt_q));
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_d == CNT_FULL) begin
                    word_done_c = 1'b1;
                    word_c      = shift_d;
                end
            end
        end

        if (word_done_c) begin
            if (state_q == ST_LEFT) begin
                left_hold_d = word_c;
                left_vld_d  = 1'b1;
            end else if (left_vld_q) begin
                pair_form_c = 1'b1;
                left_vld_d  = 1'b0;
            end
        end

        if (!enable) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            shift_d     = '0;
            left_hold_d = '0;
            left_vld_d  = 1'b0;
            pair_form_c = 1'b0;
        end

        // Clear first so a same-cycle drop wins.
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end

        if (pair_form_c) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_left_d  = left_hold_q;
                out_right_d = word_c;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Scoreboard bench for audio_i2s_rx: the stimulus thread pushes expected
// pairs as frames are sent; a negedge monitor pops and compares on every
// transfer and checks pin-to-valid latency.
`timescale 1ns/1ps
module tb_audio_i2s_rx;

    localparam int unsigned W = 16;
    localparam int ACT_NONE = 0;
    localparam int EN_OFF   = 1;
    localparam int EN_ON    = 2;
    localparam int RST_ON   = 3;
    localparam int RST_OFF  = 4;

    logic clk = 1'b0;
    logic reset;
    logic audio_bclk, audio_adclrc, audio_adcdat;
    logic enable, out_ready, clr_overflow;
    logic out_valid, overflow;
    logic [W-1:0] out_left, out_right;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    pair_t   exp_q[$];
    int      n_chk = 0;
    int      n_pass = 0;
    realtime lat_t = -1.0;
    bit      sync_mode = 1'b0;
    bit      same_arm = 1'b0;
    int      half_min = 40;
    int      half_max = 40;
    logic    prev_valid = 1'b0;

    always #5 clk = ~clk;

    audio_i2s_rx #(.SAMPLE_BITS(W), .MIN_CLK_PER_BCLK(4)) dut (
        .clk(clk), .reset(reset),
        .audio_bclk(audio_bclk), .audio_adclrc(audio_adclrc), .audio_adcdat(audio_adcdat),
        .enable(enable),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_left(out_left), .out_right(out_right),
        .overflow(overflow), .clr_overflow(clr_overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        exp_q.push_back(p);
    endtask

    task automatic half_wait();
        if (sync_mode) begin
            repeat (4) @(posedge clk);
            #1;
        end else begin
            #($urandom_range(half_max, half_min));
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
    endtask

    task automatic do_act(input int act);
        case (act)
            EN_OFF:  begin @(posedge clk); #1 enable = 1'b0; end
            EN_ON:   begin @(posedge clk); #1 enable = 1'b1; end
            RST_ON:  reset = 1'b1;
            RST_OFF: begin @(negedge clk); reset = 1'b0; end
            default: ;
        endcase
    endtask

    // One LR slot: rise 0 is the delay slot, then nbits of word MSB first, rest junk.
    task automatic send_slot(input logic lrc, input logic [31:0] word, input int nbits,
                             input int slot_len, input int act_k, input int act);
        for (int k = 0; k < slot_len; k++) begin
            logic d;
            d = 1'($urandom_range(1, 0));
            if (k >= 1 && k <= nbits) d = word[nbits-k];
            audio_bclk   = 1'b0;
            audio_adclrc = lrc;
            audio_adcdat = d;
            half_wait();
            audio_bclk = 1'b1;
            if (k == 0 && !lrc) lat_t = -1.0;
            if (lrc && k == int'(W) && nbits >= int'(W)) begin
                lat_t = $realtime;
                if (same_arm) begin
                    @(posedge clk);
                    @(posedge clk);
                    #1 out_ready = 1'b1;
                    @(posedge clk);
                    #1 out_ready = 1'b0;
                    chk("same_cycle_valid", 32'(out_valid), 32'd1);
                end
            end
            if (k == act_k) do_act(act);
            half_wait();
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                              input int nbits, input int slot_len);
        send_slot(1'b0, l, nbits, slot_len, -1, ACT_NONE);
        send_slot(1'b1, r, nbits, slot_len, -1, ACT_NONE);
    endtask

    // Monitor: latency on valid rise, scoreboard compare on each transfer.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid && lat_t >= 0.0) begin
                chk("latency", 32'(($realtime - lat_t) <= 45.0), 32'd1);
                lat_t = -1.0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_pair: got L=0x%0h R=0x%0h, want no transfer",
                             out_left, out_right);
                end else begin
                    pair_t e;
                    e = exp_q.pop_front();
                    chk("pair_left", 32'(out_left), 32'(e.l));
                    chk("pair_right", 32'(out_right), 32'(e.r));
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, want finish before 5ms");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        audio_bclk = 1'b0;
        audio_adclrc = 1'b0;
        audio_adcdat = 1'b0;
        enable = 1'b0;
        out_ready = 1'b1;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_left", 32'(out_left), 32'd0);
        chk("rst_right", 32'(out_right), 32'd0);
        @(negedge clk) reset = 1'b0;
        do_act(EN_ON);

        // Short right slot so the first left slot is a 1->0 change.
        send_slot(1'b1, 32'd0, 0, 4, -1, ACT_NONE);

        // Basic frames, clk:bclk = 8, 32-bit slots (extra bits ignored).
        push(16'hA5C3, 16'h1234); send_frame(32'hA5C3, 32'h1234, 16, 32);
        push(16'hFFFF, 16'h0001); send_frame(32'hFFFF, 32'h0001, 16, 32);
        push(16'h8000, 16'h7FFF); send_frame(32'h8000, 32'h7FFF, 16, 32);

        // 12-bit slots: words left-justified with zero LSBs.
        push(16'hABC0, 16'h5A50); send_frame(32'hABC, 32'h5A5, 12, 13);
        push(16'h1357, 16'h2468); send_frame(32'h1357, 32'h2468, 16, 32);

        // Back-pressure over two frames: first held, second dropped.
        set_ready(1'b0);
        push(16'h1111, 16'h2222); send_frame(32'h1111, 32'h2222, 16, 32);
        send_frame(32'h3333, 32'h4444, 16, 32);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("held_valid", 32'(out_valid), 32'd1);
        chk("held_left", 32'(out_left), 32'h1111);
        chk("held_right", 32'(out_right), 32'h2222);
        set_ready(1'b1);
        @(posedge clk);
        #1 clr_overflow = 1'b1;
        @(posedge clk);
        #1 clr_overflow = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        chk("valid_after_xfer", 32'(out_valid), 32'd0);

        // Ready only in the cycle a new pair forms: old transfers, new loads.
        sync_mode = 1'b1;
        set_ready(1'b0);
        push(16'hCAFE, 16'h0BAD); send_frame(32'hCAFE, 32'h0BAD, 16, 32);
        push(16'hFACE, 16'hD00D);
        same_arm = 1'b1;
        send_frame(32'hFACE, 32'hD00D, 16, 32);
        same_arm = 1'b0;
        chk("same_no_ovf", 32'(overflow), 32'd0);
        chk("same_valid", 32'(out_valid), 32'd1);
        chk("same_left", 32'(out_left), 32'hFACE);
        chk("same_right", 32'(out_right), 32'hD00D);
        set_ready(1'b1);
        sync_mode = 1'b0;

        // Enable dropped mid-left, restored during right: nothing until a full frame.
        send_slot(1'b0, 32'hDEAD, 16, 32, 6, EN_OFF);
        send_slot(1'b1, 32'hBEEF, 16, 32, 4, EN_ON);
        push(16'h600D, 16'hF00D); send_frame(32'h600D, 32'hF00D, 16, 32);

        // Reset mid-left, released during right.
        send_slot(1'b0, 32'hDEAD, 16, 32, 6, RST_ON);
        send_slot(1'b1, 32'hBEEF, 16, 32, 4, RST_OFF);
        chk("valid_after_rst", 32'(out_valid), 32'd0);
        chk("ovf_after_rst", 32'(overflow), 32'd0);
        push(16'h0F0F, 16'hF0F0); send_frame(32'h0F0F, 32'hF0F0, 16, 32);

        // Jittered bclk at ratio ~4 with random words and slot lengths.
        half_min = 20;
        half_max = 29;
        repeat (150) begin
            logic [31:0] l, r;
            int slot;
            l = $urandom;
            r = $urandom;
            slot = $urandom_range(20, 17);
            push(l[W-1:0], r[W-1:0]);
            send_frame(32'(l[W-1:0]), 32'(r[W-1:0]), 16, slot);
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("ovf_end", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
